// File: rtl/log_pkg.sv
// Shared types and sizing for the sample logger packer.
// Build option: SAMPLE_MAG_EN selects 2-bit {sign,mag} samples instead of 1-bit sign samples.
package log_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARMED   = 2'd1,
    CAPTURE = 2'd2,
    DONE    = 2'd3
  } log_state_e;

  localparam int unsigned LOG_WORD_W  = 16;
  localparam int unsigned LOG_DEPTH   = 1024;
  localparam int unsigned LOG_DECIM_W = 8;
  localparam int unsigned LOG_CNT_W   = 11;

`ifdef SAMPLE_MAG_EN
  localparam int unsigned LOG_BITS_PER_SAMPLE = 2;
`else
  localparam int unsigned LOG_BITS_PER_SAMPLE = 1;
`endif

  localparam int unsigned SAMPLES_PER_WORD = LOG_WORD_W / LOG_BITS_PER_SAMPLE;

endpackage

// File: rtl/log_decim.sv
// Decimation counter: passes 1 of (ratio+1) strobes; the first strobe after load is always taken.
module log_decim
  import log_pkg::*;
#(
  parameter int unsigned DECIM_W = LOG_DECIM_W
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load_i,
  input  logic [DECIM_W-1:0] ratio_i,
  input  logic               strobe_i,
  output logic               take_c_o
);

  logic [DECIM_W-1:0] cnt_q, cnt_d;

  assign take_c_o = strobe_i && !load_i && (cnt_q == '0);

  // Load clears to zero so the next strobe is taken; each take reloads the ratio.
  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = '0;
    end else if (strobe_i) begin
      cnt_d = (cnt_q == '0) ? ratio_i : cnt_q - DECIM_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/log_sample_packer.sv
// Arm/trigger capture FSM that decimates IF samples, packs them into words and strobes the logger.
// Build option: SAMPLE_MAG_EN packs {sign,mag} pairs, 8 samples per word.
module log_sample_packer
  import log_pkg::*;
#(
  parameter int unsigned WORD_W  = LOG_WORD_W,
  parameter int unsigned DEPTH   = LOG_DEPTH,
  parameter int unsigned DECIM_W = LOG_DECIM_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 sample_en,
  input  logic                 sample_sign,
  input  logic                 sample_mag,
  input  logic                 arm,
  input  logic                 trigger,
  input  logic [DECIM_W-1:0]   decim,
  output logic                 wr,
  output logic [WORD_W-1:0]    dout,
  output logic                 busy,
  output logic                 done,
  output logic [LOG_CNT_W-1:0] word_cnt
);

  localparam int unsigned BPS    = LOG_BITS_PER_SAMPLE;
  localparam int unsigned SPW    = WORD_W / BPS;
  localparam int unsigned SCNT_W = $clog2(SPW);

  log_state_e             state_q;
  logic [DECIM_W-1:0]     decim_q;
  logic [WORD_W-1:0]      shift_q, shift_d;
  logic [SCNT_W-1:0]      scnt_q;
  logic [LOG_CNT_W-1:0]   word_cnt_q;
  logic [WORD_W-1:0]      dout_q;
  logic                   wr_q, busy_q, done_q;
  logic [BPS-1:0]         bits_c;
  logic                   strobe_c, load_c, take_c, last_c;

`ifdef SAMPLE_MAG_EN
  assign bits_c = {sample_sign, sample_mag};
`else
  logic unused_mag;
  assign unused_mag = sample_mag;
  assign bits_c     = sample_sign;
`endif

  // Arm wins over everything, so a strobe in the arm cycle is dropped.
  assign strobe_c = sample_en && !arm && (state_q == CAPTURE) &&
                    (word_cnt_q != LOG_CNT_W'(DEPTH));
  assign load_c   = arm || ((state_q == ARMED) && trigger);
  assign shift_d  = {shift_q[WORD_W-BPS-1:0], bits_c};
  assign last_c   = (scnt_q == SCNT_W'(SPW - 1));

  log_decim #(.DECIM_W(DECIM_W)) u_decim (
    .clk      (clk),
    .rst      (rst),
    .load_i   (load_c),
    .ratio_i  (decim_q),
    .strobe_i (strobe_c),
    .take_c_o (take_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      decim_q    <= '0;
      shift_q    <= '0;
      scnt_q     <= '0;
      word_cnt_q <= '0;
      dout_q     <= '0;
      wr_q       <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      wr_q <= 1'b0;
      if (arm) begin
        state_q    <= ARMED;
        decim_q    <= decim;
        shift_q    <= '0;
        scnt_q     <= '0;
        word_cnt_q <= '0;
        busy_q     <= 1'b1;
        done_q     <= 1'b0;
      end else begin
        case (state_q)
          ARMED: begin
            if (trigger) state_q <= CAPTURE;
          end
          CAPTURE: begin
            if (take_c) begin
              shift_q <= shift_d;
              if (last_c) begin
                scnt_q     <= '0;
                dout_q     <= shift_d;
                wr_q       <= 1'b1;
                word_cnt_q <= word_cnt_q + LOG_CNT_W'(1);
                // Final word: leave CAPTURE on the same edge its wr is raised.
                if (word_cnt_q == LOG_CNT_W'(DEPTH - 1)) begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
                end
              end else begin
                scnt_q <= scnt_q + SCNT_W'(1);
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

  assign wr       = wr_q;
  assign dout     = dout_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign word_cnt = word_cnt_q;

endmodule
